// File: rtl/ctrl_pkg.sv
// Shared control definitions for the multicycle main FSM: state encodings,
// opcodes, datapath select encodings and the packed control-word type.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       adr_src;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/main_fsm_out_dec.sv
// Moore output decode: control word from current state and wait count.
// JAL outputs exist only when MAIN_FSM_JAL_EN is defined.
module main_fsm_out_dec
  import ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 0
) (
  input  state_t     i_state,
  input  logic [1:0] i_count,
  output ctrl_t      o_ctrl
);

  localparam logic [1:0] WAIT_MAX = 2'(MEM_WAIT);

  // Strobes of memory-access states fire only on the final held cycle.
  logic w_last;
  assign w_last = (i_count == WAIT_MAX);

  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.alu_src_b  = SRCB_FOUR;
        o_ctrl.result_src = RES_ALURESULT;
        o_ctrl.ir_write   = w_last;
        o_ctrl.pc_update  = w_last;
      end
      S_DECODE: begin
        o_ctrl.alu_src_a = SRCA_OLDPC;
        o_ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        o_ctrl.alu_src_a = SRCA_REG;
        o_ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: o_ctrl.adr_src = 1'b1;
      S_MEMWB: begin
        o_ctrl.result_src = RES_DATA;
        o_ctrl.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        o_ctrl.adr_src   = 1'b1;
        o_ctrl.mem_write = w_last;
      end
      S_EXECUTER: begin
        o_ctrl.alu_src_a = SRCA_REG;
        o_ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        o_ctrl.alu_src_a = SRCA_REG;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: o_ctrl.reg_write = 1'b1;
`ifdef MAIN_FSM_JAL_EN
      S_JAL: begin
        o_ctrl.alu_src_a = SRCA_OLDPC;
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.pc_update = 1'b1;
      end
`endif
      S_BEQ: begin
        o_ctrl.alu_src_a = SRCA_REG;
        o_ctrl.alu_op    = ALUOP_SUB;
        o_ctrl.branch    = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/main_fsm.sv
// Multicycle processor main control FSM with per-memory-state wait cycles.
// Optional jal support is compiled in with MAIN_FSM_JAL_EN.
module main_fsm
  import ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  output logic       PCUpdate,
  output logic       Branch,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [3:0] state_o
);

  localparam logic [1:0] WAIT_MAX = 2'(MEM_WAIT);

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_count;
  logic       r_is_load;
  logic       w_hold;
  ctrl_t      w_ctrl;

  assign w_hold = is_mem_state(r_state) && (r_count < WAIT_MAX);

  always_comb begin
    w_next = S_FETCH;
    if (w_hold) begin
      w_next = r_state;
    end else begin
      case (r_state)
        S_FETCH:  w_next = S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LOAD, OP_STORE: w_next = S_MEMADR;
            OP_RTYPE:          w_next = S_EXECUTER;
            OP_ITYPE:          w_next = S_EXECUTEI;
`ifdef MAIN_FSM_JAL_EN
            OP_JAL:            w_next = S_JAL;
`endif
            OP_BEQ:            w_next = S_BEQ;
            default:           w_next = S_FETCH;
          endcase
        end
        S_MEMADR:   w_next = r_is_load ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  w_next = S_MEMWB;
        S_EXECUTER: w_next = S_ALUWB;
        S_EXECUTEI: w_next = S_ALUWB;
`ifdef MAIN_FSM_JAL_EN
        S_JAL:      w_next = S_ALUWB;
`endif
        default:    w_next = S_FETCH;
      endcase
    end
  end

  // The counter returns to zero whenever a state is not held, so each
  // memory-access state is always entered with a cleared count.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_count   <= 2'd0;
      r_is_load <= 1'b0;
    end else begin
      r_state <= w_next;
      r_count <= w_hold ? r_count + 2'd1 : 2'd0;
      if (r_state == S_DECODE) r_is_load <= (op == OP_LOAD);
    end
  end

  main_fsm_out_dec #(.MEM_WAIT(MEM_WAIT)) u_out_dec (
    .i_state (r_state),
    .i_count (r_count),
    .o_ctrl  (w_ctrl)
  );

  // Strobes are gated by reset so they drop immediately, even in FETCH.
  assign PCUpdate  = w_ctrl.pc_update & rst_n;
  assign Branch    = w_ctrl.branch    & rst_n;
  assign IRWrite   = w_ctrl.ir_write  & rst_n;
  assign MemWrite  = w_ctrl.mem_write & rst_n;
  assign RegWrite  = w_ctrl.reg_write & rst_n;
  assign AdrSrc    = w_ctrl.adr_src;
  assign ResultSrc = w_ctrl.result_src;
  assign ALUSrcA   = w_ctrl.alu_src_a;
  assign ALUSrcB   = w_ctrl.alu_src_b;
  assign ALUOp     = w_ctrl.alu_op;
  assign state_o   = r_state;

endmodule

// File: doc/main_fsm.md
MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 Parameter: MEM_WAIT, 0, extra wait cycles (legal 0..3) held in each memory-access state (FETCH, MEMREAD, MEMWRITE).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 op  input  7  opcode from the instruction register, sampled only in DECODE.
REQ-005 PCUpdate  output  1  unconditional PC write strobe.
REQ-006 Branch  output  1  conditional PC write request, combined with ALU zero outside this block.
REQ-007 IRWrite  output  1  instruction register load strobe.
REQ-008 MemWrite  output  1  data memory write strobe.
REQ-009 RegWrite  output  1  register file write strobe.
REQ-010 AdrSrc  output  1  memory address select (0 = PC, 1 = result).
REQ-011 ResultSrc  output  2  result mux select.
REQ-012 ALUSrcA  output  2  ALU A operand select.
REQ-013 ALUSrcB  output  2  ALU B operand select.
REQ-014 ALUOp  output  2  ALU operation class for the ALU decoder.
REQ-015 state_o  output  4  current state encoding, for debug.

Function
REQ-016 Moore FSM; all outputs are a combinational decode of the current state and wait count only.
REQ-017 State encodings:
- FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5
- EXECUTER = 6, ALUWB = 7, EXECUTEI = 8, JAL = 9, BEQ = 10
- 11..15 are unused and return to FETCH on the next edge.
REQ-018 DECODE transitions on op:
- 0000011 or 0100011 -> MEMADR
- 0110011 -> EXECUTER
- 0010011 -> EXECUTEI
- 1101111 -> JAL
- 1100011 -> BEQ
- any other value -> FETCH (instruction dropped, no strobes).
REQ-019 Remaining transitions:
- MEMADR -> MEMREAD if the DECODE-latched op was load, else MEMWRITE
- MEMREAD -> MEMWB
- EXECUTER -> ALUWB; EXECUTEI -> ALUWB; JAL -> ALUWB
- MEMWB, MEMWRITE, ALUWB, BEQ -> FETCH.
REQ-020 DECODE latches one bit, is_load, consumed in MEMADR; op changes after DECODE have no effect.
REQ-021 Wait counter: 2 bits, cleared on entering each memory-access state. The state is held while count < MEM_WAIT; the counter increments each held cycle.
REQ-022 Non-default output values per state (all other outputs are 0):
- FETCH: ALUSrcB=10, ResultSrc=10
- DECODE: ALUSrcA=01, ALUSrcB=01
- MEMADR: ALUSrcA=10, ALUSrcB=01
- MEMREAD: AdrSrc=1
- MEMWB: ResultSrc=01, RegWrite=1
- MEMWRITE: AdrSrc=1
- EXECUTER: ALUSrcA=10, ALUOp=10
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10
- ALUWB: RegWrite=1
- JAL: ALUSrcA=01, ALUSrcB=10, PCUpdate=1
- BEQ: ALUSrcA=10, ALUOp=01, Branch=1
REQ-023 Strobes in memory-access states assert only on the final cycle (count == MEM_WAIT):
- FETCH: IRWrite=1, PCUpdate=1
- MEMWRITE: MemWrite=1
REQ-024 Latency with MEM_WAIT=0: load 5, store 4, R/I 4, jal 4, beq 3 cycles; each memory-access state adds MEM_WAIT cycles.

Reset
REQ-025 While rst_n=0: state=FETCH, counter=0, is_load=0, and PCUpdate, Branch, IRWrite, MemWrite, RegWrite are forced to 0 regardless of state.
REQ-026 Reset asserted mid-instruction aborts it immediately; the first edge after deassertion evaluates FETCH with count 0.

Configuration
REQ-027 Macro MAIN_FSM_JAL_EN. When defined, the JAL state and the 1101111 decode are present. When undefined, 1101111 takes the unknown-opcode path to FETCH, and encoding 9 behaves as unused.

Structure
REQ-028 Shared package ctrl_pkg holds the state encodings, the opcode constants, and the ResultSrc/ALUSrcA/ALUSrcB/ALUOp encodings.
REQ-029 One sub-module, main_fsm_out_dec, provides the combinational state-to-output decode. The state register, wait counter and is_load stay in main_fsm.

Verification
REQ-030 Reset with FETCH active, then deassert, MEM_WAIT=0 -> IRWrite=1 and PCUpdate=1 on the first cycle, state_o=1 on the next.
REQ-031 op=0000011 -> state_o sequence 0,1,2,3,4,0; RegWrite=1 only at 4 with ResultSrc=01.
REQ-032 MEM_WAIT=2, op=0100011 -> FETCH lasts 3 cycles with IRWrite only on the 3rd; MEMWRITE lasts 3 cycles with MemWrite only on the 3rd.
REQ-033 op=1100011 -> sequence 0,1,10,0; Branch=1 and ALUOp=01 in state 10; op=1111111 -> sequence 0,1,0 with no strobes.
REQ-034 MAIN_FSM_JAL_EN defined, op=1101111 -> sequence 0,1,9,7,0; macro undefined -> 0,1,0.
REQ-035 rst_n pulsed low while in MEMWB -> strobes drop asynchronously, state_o=0, and RegWrite is not asserted again until the next load.
